// File: rtl/score_controller.sv
// score_controller
//   Serialises pellet / power-pellet / ghost / fruit award requests into a
//   running score. Each served request takes one pass IDLE->GRANT->ADD->CHECK.
//   Score saturates at SCORE_MAX. One extra life is awarded per game on the
//   first crossing of EXTRA_LIFE_AT.
//
//   Optional feature: define SCORE_HIGH_SCORE_EN to keep a best-since-reset
//   high score. Without it, high_score is tied to zero.
//
// Ports
//   clk          sole clock, rising edge
//   rst          asynchronous active-high reset
//   new_game     one-cycle pulse: clear score/combo/life flag, abort sequence
//   *_req        award requests, held until the matching *_ack
//   fruit_value  fruit award (units of 10), stable while fruit_req is high
//   *_ack        one-cycle grant pulses, issued in GRANT
//   score        current score (units of 10)
//   high_score   best score since reset (units of 10), 0 when feature is off
//   extra_life   one-cycle pulse on the first threshold crossing in a game
//   busy         high whenever the sequencer is not idle
module score_controller #(
    parameter logic [17:0] SCORE_MAX     = 18'd99999,
    parameter logic [17:0] EXTRA_LIFE_AT = 18'd1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_game,
    input  logic        pellet_req,
    input  logic        power_req,
    input  logic        ghost_req,
    input  logic        fruit_req,
    input  logic [9:0]  fruit_value,
    output logic        pellet_ack,
    output logic        power_ack,
    output logic        ghost_ack,
    output logic        fruit_ack,
    output logic [17:0] score,
    output logic [17:0] high_score,
    output logic        extra_life,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, GRANT, ADD, CHECK} state_t;

    state_t      state_q, state_d;
    logic [3:0]  win_q, win_d;       // one-hot winner: [0]pellet [1]power [2]ghost [3]fruit
    logic [9:0]  award_q, award_d;
    logic [1:0]  combo_q, combo_d;
    logic        life_q, life_d;
    logic        xl_q, xl_d;
    logic [17:0] score_q, score_d;
    logic        rst_hold_q;         // blocks granting on the first edge after reset
    logic [18:0] sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            win_q      <= '0;
            award_q    <= '0;
            combo_q    <= '0;
            life_q     <= 1'b0;
            xl_q       <= 1'b0;
            score_q    <= '0;
            rst_hold_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            award_q    <= award_d;
            combo_q    <= combo_d;
            life_q     <= life_d;
            xl_q       <= xl_d;
            score_q    <= score_d;
            rst_hold_q <= 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        award_d = award_q;
        combo_d = combo_q;
        life_d  = life_q;
        xl_d    = 1'b0;
        score_d = score_q;
        sum     = {1'b0, score_q} + {9'd0, award_q};

        unique case (state_q)
            IDLE: begin
                // Award is captured together with the winner so the ack
                // pulse and the amount always refer to the same request.
                if (!rst_hold_q) begin
                    if (ghost_req) begin
                        state_d = GRANT;
                        win_d   = 4'b0100;
                        award_d = 10'd20 << combo_q;
                    end else if (fruit_req) begin
                        state_d = GRANT;
                        win_d   = 4'b1000;
                        award_d = fruit_value;
                    end else if (power_req) begin
                        state_d = GRANT;
                        win_d   = 4'b0010;
                        award_d = 10'd5;
                    end else if (pellet_req) begin
                        state_d = GRANT;
                        win_d   = 4'b0001;
                        award_d = 10'd1;
                    end
                end
            end
            GRANT: state_d = ADD;
            ADD: begin
                state_d = CHECK;
                score_d = (sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : sum[17:0];
                if (win_q[2]) begin
                    combo_d = (combo_q == 2'd3) ? 2'd3 : combo_q + 2'd1;
                end else if (win_q[1]) begin
                    combo_d = '0;
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (score_q >= EXTRA_LIFE_AT && !life_q) begin
                    xl_d   = 1'b1;
                    life_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // new_game overrides everything above; a latched award is dropped.
        if (new_game) begin
            state_d = IDLE;
            score_d = '0;
            combo_d = '0;
            life_d  = 1'b0;
            xl_d    = 1'b0;
        end
    end

`ifdef SCORE_HIGH_SCORE_EN
    logic [17:0] high_q, high_d;

    // The score being checked still counts even if new_game lands in CHECK.
    always_comb begin
        high_d = high_q;
        if (state_q == CHECK && score_q > high_q) begin
            high_d = score_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            high_q <= '0;
        end else begin
            high_q <= high_d;
        end
    end

    assign high_score = high_q;
`else
    assign high_score = '0;
`endif

    always_comb begin
        pellet_ack = (state_q == GRANT) && win_q[0];
        power_ack  = (state_q == GRANT) && win_q[1];
        ghost_ack  = (state_q == GRANT) && win_q[2];
        fruit_ack  = (state_q == GRANT) && win_q[3];
        busy       = (state_q != IDLE);
        score      = score_q;
        extra_life = xl_q;
    end

endmodule

// File: tb/tb_score_controller.sv
module tb_score_controller;

    logic        clk = 1'b0, rst = 1'b0, new_game = 1'b0;
    logic        pellet_req = 1'b0, power_req = 1'b0, ghost_req = 1'b0, fruit_req = 1'b0;
    logic [9:0]  fruit_value = '0;
    logic        pellet_ack, power_ack, ghost_ack, fruit_ack, extra_life, busy;
    logic [17:0] score, high_score;

    always #5 clk = ~clk;

    score_controller #(.SCORE_MAX(18'd99999), .EXTRA_LIFE_AT(18'd1000)) dut (
        .clk(clk), .rst(rst), .new_game(new_game),
        .pellet_req(pellet_req), .power_req(power_req),
        .ghost_req(ghost_req), .fruit_req(fruit_req), .fruit_value(fruit_value),
        .pellet_ack(pellet_ack), .power_ack(power_ack),
        .ghost_ack(ghost_ack), .fruit_ack(fruit_ack),
        .score(score), .high_score(high_score),
        .extra_life(extra_life), .busy(busy)
    );

    int n_cmp = 0, n_bad = 0;
    int xl_cnt = 0;
    bit chk_en = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_true(input string name, input bit cond);
        n_cmp++;
        if (!cond) begin
            n_bad++;
            $display("FAIL %s: condition not met within bound", name);
        end
    endtask

    // Reference model: a served request is a 3-cycle transaction timeline.
    // age 0 = grant cycle, 1 = score being added, 2 = score visible / checked.
    int m_age, m_kind, m_award, m_score, m_high, m_combo;
    bit m_life, m_xl, m_first;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_age = -1; m_kind = 0; m_award = 0; m_score = 0; m_high = 0;
            m_combo = 0; m_life = 0; m_xl = 0; m_first = 1;
        end else begin
            m_xl = 0;
            if (m_age == 2) begin
                if (m_score >= 1000 && !m_life) begin m_xl = 1; m_life = 1; end
                if (m_score > m_high) m_high = m_score;
            end
            if (m_age == 1) begin
                m_score = m_score + m_award;
                if (m_score > 99999) m_score = 99999;
                if (m_kind == 2) m_combo = (m_combo == 3) ? 3 : m_combo + 1;
                else if (m_kind == 1) m_combo = 0;
            end
            if (m_age >= 0) begin
                m_age = (m_age == 2) ? -1 : m_age + 1;
            end else if (!m_first) begin
                if (ghost_req)       begin m_age = 0; m_kind = 2; m_award = 20 * (1 << m_combo); end
                else if (fruit_req)  begin m_age = 0; m_kind = 3; m_award = int'(fruit_value); end
                else if (power_req)  begin m_age = 0; m_kind = 1; m_award = 5; end
                else if (pellet_req) begin m_age = 0; m_kind = 0; m_award = 1; end
            end
            m_first = 0;
            if (new_game) begin
                m_score = 0; m_combo = 0; m_life = 0; m_xl = 0; m_age = -1;
            end
        end
    end

    logic [41:0] exp_vec, act_vec;
    int exp_high;

    always @(negedge clk) begin
        if (chk_en) begin
`ifdef SCORE_HIGH_SCORE_EN
            exp_high = m_high;
`else
            exp_high = 0;
`endif
            exp_vec = {m_age == 0 && m_kind == 2, m_age == 0 && m_kind == 3,
                       m_age == 0 && m_kind == 1, m_age == 0 && m_kind == 0,
                       m_age >= 0, m_xl, 18'(m_score), 18'(exp_high)};
            act_vec = {ghost_ack, fruit_ack, power_ack, pellet_ack,
                       busy, extra_life, score, high_score};
            n_cmp++;
            if (act_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL outputs @%0t: got acks=%b busy=%b xl=%b score=%0d high=%0d expected acks=%b busy=%b xl=%b score=%0d high=%0d",
                         $time, act_vec[41:38], act_vec[37], act_vec[36], act_vec[35:18], act_vec[17:0],
                         exp_vec[41:38], exp_vec[37], exp_vec[36], exp_vec[35:18], exp_vec[17:0]);
            end
        end
    end

    always @(negedge clk) if (extra_life) xl_cnt++;

    // kind: 0 pellet, 1 power, 2 ghost, 3 fruit
    task automatic set_req(input int k, input logic v);
        case (k)
            0: pellet_req = v;
            1: power_req  = v;
            2: ghost_req  = v;
            default: fruit_req = v;
        endcase
    endtask

    function automatic logic ack_of(input int k);
        case (k)
            0: return pellet_ack;
            1: return power_ack;
            2: return ghost_ack;
            default: return fruit_ack;
        endcase
    endfunction

    task automatic serve(input int k, input logic [9:0] fv);
        bit got = 0;
        if (k == 3) fruit_value = fv;
        set_req(k, 1'b1);
        for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = ack_of(k); end
        set_req(k, 1'b0);
        expect_true("serve_ack", got);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = !busy; end
        expect_true("serve_idle", got);
    endtask

    task automatic pulse_new_game();
        @(negedge clk); new_game = 1'b1;
        @(negedge clk); new_game = 1'b0;
    endtask

    function automatic logic next_req(input logic cur, input logic ack);
        if (cur && ack) return 1'b0;
        if (!cur) return ($urandom_range(7, 0) == 0);
        return ($urandom_range(63, 0) != 0);
    endfunction

    initial begin
        int cnt;
        int xl_before;
        bit got;
        logic nf;
        int exp_hs;

        // Pellet held from reset.
        #1 rst = 1'b1;
        pellet_req = 1'b1;
        chk_en = 1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("no_grant_first_edge", pellet_ack, 0);
        check("idle_first_edge", busy, 0);
        @(negedge clk);
        check("pellet_ack_c1", pellet_ack, 1);
        check("busy_c1", busy, 1);
        check("score_c1", score, 0);
        pellet_req = 1'b0;
        @(negedge clk);
        check("busy_c2", busy, 1);
        check("score_c2", score, 0);
        @(negedge clk);
        check("score_c3", score, 1);
        check("busy_c3", busy, 1);
        @(negedge clk);
        check("busy_c4", busy, 0);

        // Simultaneous ghost and pellet: ghost wins.
        pulse_new_game();
        pellet_req = 1'b1; ghost_req = 1'b1;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk); got = ghost_ack | pellet_ack;
        end
        check("prio_ghost_ack", ghost_ack, 1);
        check("prio_pellet_noack", pellet_ack, 0);
        ghost_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("prio_score_ghost", score, 20);
        cnt = 2; got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk); cnt++; got = pellet_ack;
        end
        check("prio_pellet_gap", cnt, 4);
        pellet_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("prio_score_pellet", score, 21);
        @(negedge clk);

        // Ghost combo sequence.
        pulse_new_game();
        serve(2, '0); check("combo_g1", score, 20);
        serve(2, '0); check("combo_g2", score, 60);
        serve(2, '0); check("combo_g3", score, 140);
        serve(2, '0); check("combo_g4", score, 300);
        serve(1, '0); check("combo_power", score, 305);
        serve(2, '0); check("combo_g_after_power", score, 325);

        // Saturation and single extra life.
        pulse_new_game();
        xl_before = xl_cnt;
        for (int i = 0; i < 97; i++) serve(3, 10'd1023);
        check("sat_pre", score, 99231);
        serve(3, 10'd759);
        check("sat_99990", score, 99990);
        serve(3, 10'd500);
        check("sat_max", score, 99999);
        serve(3, 10'd1);
        check("sat_hold", score, 99999);
        check("extra_life_once", xl_cnt - xl_before, 1);

        // new_game during ADD discards the award.
        pulse_new_game();
        fruit_value = 10'd300; fruit_req = 1'b1;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin @(negedge clk); got = fruit_ack; end
        expect_true("ng_fruit_ack", got);
        fruit_req = 1'b0;
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
`ifdef SCORE_HIGH_SCORE_EN
        exp_hs = 99999;
`else
        exp_hs = 0;
`endif
        check("ng_score", score, 0);
        check("ng_busy", busy, 0);
        check("ng_high", high_score, exp_hs);
        repeat (4) @(negedge clk);
        check("ng_award_lost", score, 0);

        // Randomized traffic checked by the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            pellet_req = next_req(pellet_req, pellet_ack);
            power_req  = next_req(power_req, power_ack);
            ghost_req  = next_req(ghost_req, ghost_ack);
            nf = next_req(fruit_req, fruit_ack);
            if (nf && !fruit_req) fruit_value = 10'($urandom_range(1023, 0));
            fruit_req = nf;
            new_game = ($urandom_range(149, 0) == 0);
        end
        @(negedge clk);
        new_game = 1'b0; pellet_req = 1'b0; power_req = 1'b0;
        ghost_req = 1'b0; fruit_req = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = !busy; end
        expect_true("random_drain", got);

        // Asynchronous reset in CHECK.
        pulse_new_game();
        pellet_req = 1'b1;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin @(negedge clk); got = pellet_ack; end
        expect_true("rst_pellet_ack", got);
        pellet_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_score", score, 0);
        check("rst_busy", busy, 0);
        check("rst_high", high_score, 0);
        check("rst_acks", {pellet_ack, power_ack, ghost_ack, fruit_ack}, 0);
        check("rst_xl", extra_life, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
